// File: rtl/writeback_if.sv
// Writeback stage bus bundle: execute handoff, load response,
// register-file write port, hazard and error indications.
interface writeback_if;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_load;
    logic        ex_wren;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic [1:0]  ex_lsize;
    logic        ex_lsign;
    logic [1:0]  ex_laddr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_wren;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        pend_valid;
    logic [4:0]  pend_rd;
    logic        err_timeout;
    logic        err_spurious;

    // Environment side: execute stage, memory and register file.
    modport master (
        output ex_valid, ex_load, ex_wren, ex_rd, ex_result,
        output ex_lsize, ex_lsign, ex_laddr,
        output mem_rvalid, mem_rdata,
        input  ex_ready, wb_wren, wb_waddr, wb_wdata,
        input  pend_valid, pend_rd, err_timeout, err_spurious
    );

    // Writeback stage side.
    modport slave (
        input  ex_valid, ex_load, ex_wren, ex_rd, ex_result,
        input  ex_lsize, ex_lsign, ex_laddr,
        input  mem_rvalid, mem_rdata,
        output ex_ready, wb_wren, wb_waddr, wb_wdata,
        output pend_valid, pend_rd, err_timeout, err_spurious
    );
endinterface

// File: rtl/writeback.sv
// Writeback stage: retires ALU results in one cycle, waits for
// load data with a timeout, aligns/extends it and writes rd.
module writeback #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic       clk,
    input  logic       rst,
    writeback_if.slave bus
);

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } state_t;

    localparam logic [15:0] LP_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [4:0]  r_rd;
    logic        r_wren;
    logic [1:0]  r_lsize;
    logic        r_lsign;
    logic [1:0]  r_laddr;
    logic        r_wb_wren;
    logic [4:0]  r_wb_waddr;
    logic [31:0] r_wb_wdata;
    logic        r_tmo;
    logic        r_spur;

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ldata;
    logic        w_pend;

    // Select and extend the addressed byte/half of the load word.
    always_comb begin
        w_byte  = 8'h00;
        w_half  = 16'h0000;
        w_ldata = bus.mem_rdata;
        case (r_laddr)
            2'd0:    w_byte = bus.mem_rdata[7:0];
            2'd1:    w_byte = bus.mem_rdata[15:8];
            2'd2:    w_byte = bus.mem_rdata[23:16];
            default: w_byte = bus.mem_rdata[31:24];
        endcase
        w_half = r_laddr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (r_lsize)
            2'd0:    w_ldata = {{24{r_lsign & w_byte[7]}}, w_byte};
            2'd1:    w_ldata = {{16{r_lsign & w_half[15]}}, w_half};
            default: w_ldata = bus.mem_rdata;
        endcase
    end

    // Control FSM with registered write port and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rd       <= '0;
            r_wren     <= 1'b0;
            r_lsize    <= '0;
            r_lsign    <= 1'b0;
            r_laddr    <= '0;
            r_wb_wren  <= 1'b0;
            r_wb_waddr <= '0;
            r_wb_wdata <= '0;
            r_tmo      <= 1'b0;
            r_spur     <= 1'b0;
        end else begin
            r_wb_wren <= 1'b0;
            r_tmo     <= 1'b0;
            r_spur    <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_spur <= bus.mem_rvalid;
                    if (bus.ex_valid) begin
                        if (bus.ex_load) begin
                            r_rd    <= bus.ex_rd;
                            r_wren  <= bus.ex_wren;
                            r_lsize <= bus.ex_lsize;
                            r_lsign <= bus.ex_lsign;
                            r_laddr <= bus.ex_laddr;
                            r_cnt   <= '0;
                            r_state <= WAIT_LOAD;
                        end else begin
                            r_wb_wren  <= bus.ex_wren && (bus.ex_rd != 5'd0);
                            r_wb_waddr <= bus.ex_rd;
                            r_wb_wdata <= bus.ex_result;
                        end
                    end
                end
                WAIT_LOAD: begin
                    if (bus.mem_rvalid) begin
                        r_wb_wren  <= r_wren && (r_rd != 5'd0);
                        r_wb_waddr <= r_rd;
                        r_wb_wdata <= w_ldata;
                        r_state    <= IDLE;
                    end else if (r_cnt == LP_LAST) begin
                        r_tmo   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_pend           = (r_state == WAIT_LOAD) && r_wren && (r_rd != 5'd0);
    assign bus.ex_ready     = (r_state == IDLE);
    assign bus.pend_valid   = w_pend;
    assign bus.pend_rd      = w_pend ? r_rd : 5'd0;
    assign bus.wb_wren      = r_wb_wren;
    assign bus.wb_waddr     = r_wb_waddr;
    assign bus.wb_wdata     = r_wb_wdata;
    assign bus.err_timeout  = r_tmo;
    assign bus.err_spurious = r_spur;

endmodule

// File: tb/tb_writeback.sv
// Randomized bench for the writeback stage, checked against a
// transaction-level reference model with directed corner cases.
module tb_writeback;

    localparam int TMO = 4;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    writeback_if wbi();

    writeback #(.TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (wbi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: outstanding load and how long it has waited
    bit          m_busy;
    int          m_waited;
    logic [4:0]  m_rd;
    bit          m_wren;
    logic [1:0]  m_lsize;
    bit          m_lsign;
    logic [1:0]  m_laddr;
    bit          last_accept;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [1:0] sz,
                                             input bit sg,
                                             input logic [1:0] off,
                                             input logic [31:0] word);
        longint v;
        if (sz == 2'd0) begin
            v = (longint'(word) >> (8 * int'(off))) % 256;
            if (sg && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            v = (longint'(word) >> (16 * (int'(off) / 2))) % 65536;
            if (sg && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(word);
        end
        return v[31:0];
    endfunction

    task automatic idle_inputs();
        wbi.ex_valid   = 1'b0;
        wbi.ex_load    = 1'b0;
        wbi.ex_wren    = 1'b0;
        wbi.ex_rd      = '0;
        wbi.ex_result  = '0;
        wbi.ex_lsize   = '0;
        wbi.ex_lsign   = 1'b0;
        wbi.ex_laddr   = '0;
        wbi.mem_rvalid = 1'b0;
        wbi.mem_rdata  = '0;
    endtask

    // One clock cycle: drive, check combinational status, advance
    // the model, clock, check registered outputs.
    task automatic step(input bit v, input bit ld, input bit we,
                        input logic [4:0] rd, input logic [31:0] res,
                        input logic [1:0] sz, input bit sg,
                        input logic [1:0] off, input bit rv,
                        input logic [31:0] rdat);
        bit          e_wr;
        bit          e_tmo;
        bit          e_spur;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        bit          pend;
        wbi.ex_valid   = v;
        wbi.ex_load    = ld;
        wbi.ex_wren    = we;
        wbi.ex_rd      = rd;
        wbi.ex_result  = res;
        wbi.ex_lsize   = sz;
        wbi.ex_lsign   = sg;
        wbi.ex_laddr   = off;
        wbi.mem_rvalid = rv;
        wbi.mem_rdata  = rdat;
        #1;
        pend = m_busy && m_wren && (m_rd != 5'd0);
        chk("ex_ready", 32'(wbi.ex_ready), 32'(!m_busy));
        chk("pend_valid", 32'(wbi.pend_valid), 32'(pend));
        chk("pend_rd", 32'(wbi.pend_rd), pend ? 32'(m_rd) : 32'd0);
        e_wr = 0; e_tmo = 0; e_spur = 0; e_addr = '0; e_data = '0;
        last_accept = 0;
        if (!m_busy) begin
            e_spur = rv;
            if (v) begin
                last_accept = 1;
                if (!ld) begin
                    e_wr   = we && (rd != 5'd0);
                    e_addr = rd;
                    e_data = res;
                end else begin
                    m_busy   = 1;
                    m_waited = 0;
                    m_rd     = rd;
                    m_wren   = we;
                    m_lsize  = sz;
                    m_lsign  = sg;
                    m_laddr  = off;
                end
            end
        end else if (rv) begin
            e_wr   = m_wren && (m_rd != 5'd0);
            e_addr = m_rd;
            e_data = ref_load(m_lsize, m_lsign, m_laddr, rdat);
            m_busy = 0;
        end else begin
            m_waited++;
            if (m_waited == TMO) begin
                e_tmo  = 1;
                m_busy = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("wb_wren", 32'(wbi.wb_wren), 32'(e_wr));
        if (e_wr) begin
            chk("wb_waddr", 32'(wbi.wb_waddr), 32'(e_addr));
            chk("wb_wdata", wbi.wb_wdata, e_data);
        end
        chk("err_timeout", 32'(wbi.err_timeout), 32'(e_tmo));
        chk("err_spurious", 32'(wbi.err_spurious), 32'(e_spur));
    endtask

    task automatic nop(input bit rv, input logic [31:0] rdat);
        step(0, 0, 0, 5'd0, 32'd0, 2'd0, 0, 2'd0, rv, rdat);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wren"}, 32'(wbi.wb_wren), 32'd0);
        chk({tag, "_waddr"}, 32'(wbi.wb_waddr), 32'd0);
        chk({tag, "_wdata"}, wbi.wb_wdata, 32'd0);
        chk({tag, "_pendv"}, 32'(wbi.pend_valid), 32'd0);
        chk({tag, "_pendrd"}, 32'(wbi.pend_rd), 32'd0);
        chk({tag, "_tmo"}, 32'(wbi.err_timeout), 32'd0);
        chk({tag, "_spur"}, 32'(wbi.err_spurious), 32'd0);
    endtask

    logic [31:0] h_res, h_rdat;
    logic [4:0]  h_rd;
    logic [1:0]  h_sz, h_off;
    bit          h_v, h_ld, h_we, h_sg, h_rv;

    initial begin
        n_vec = 0;
        n_err = 0;
        m_busy = 0; m_waited = 0; m_rd = '0; m_wren = 0;
        m_lsize = '0; m_lsign = 0; m_laddr = '0; last_accept = 0;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst");
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(wbi.ex_ready), 32'd1);

        // ALU write and rd=0 suppression
        step(1, 0, 1, 5'd5, 32'hDEADBEEF, 2'd0, 0, 2'd0, 0, 32'd0);
        chk("alu_x5", wbi.wb_wdata, 32'hDEADBEEF);
        step(1, 0, 1, 5'd0, 32'h12345678, 2'd0, 0, 2'd0, 0, 32'd0);

        // signed byte load, offset 3
        step(1, 1, 1, 5'd7, 32'd0, 2'd0, 1, 2'd3, 0, 32'd0);
        nop(0, 32'd0);
        nop(1, 32'h80112233);
        chk("lb_x7", wbi.wb_wdata, 32'hFFFFFF80);

        // unsigned half offset 2, word offset 1
        step(1, 1, 1, 5'd9, 32'd0, 2'd1, 0, 2'd2, 0, 32'd0);
        nop(1, 32'hBEEF1234);
        chk("lhu", wbi.wb_wdata, 32'h0000BEEF);
        step(1, 1, 1, 5'd10, 32'd0, 2'd2, 1, 2'd1, 0, 32'd0);
        nop(1, 32'hBEEF1234);
        chk("lw", wbi.wb_wdata, 32'hBEEF1234);

        // timeout with no response, then response on last cycle
        step(1, 1, 1, 5'd11, 32'd0, 2'd2, 0, 2'd0, 0, 32'd0);
        repeat (TMO) nop(0, 32'd0);
        nop(0, 32'd0);
        step(1, 1, 1, 5'd12, 32'd0, 2'd2, 0, 2'd0, 0, 32'd0);
        repeat (TMO - 1) nop(0, 32'd0);
        nop(1, 32'hCAFEF00D);
        chk("last_cycle", wbi.wb_wdata, 32'hCAFEF00D);

        // spurious response in idle and on the accept cycle
        nop(1, 32'h1);
        step(1, 1, 1, 5'd13, 32'd0, 2'd2, 0, 2'd0, 1, 32'h2);
        nop(1, 32'h55AA55AA);

        // reset mid-load abandons it; late response is spurious
        step(1, 1, 1, 5'd14, 32'd0, 2'd2, 0, 2'd0, 0, 32'd0);
        nop(0, 32'd0);
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        m_busy = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        nop(1, 32'h77);

        // ALU held during a load, accepted after the load write
        step(1, 1, 1, 5'd3, 32'd0, 2'd2, 0, 2'd0, 0, 32'd0);
        step(1, 0, 1, 5'd4, 32'h44, 2'd0, 0, 2'd0, 0, 32'd0);
        step(1, 0, 1, 5'd4, 32'h44, 2'd0, 0, 2'd0, 1, 32'h33);
        step(1, 0, 1, 5'd4, 32'h44, 2'd0, 0, 2'd0, 0, 32'd0);
        chk("held_alu", wbi.wb_wdata, 32'h44);

        // randomized traffic; producer holds ex_* until accepted
        h_v = 0;
        for (int i = 0; i < 600; i++) begin
            if (!(h_v && !last_accept)) begin
                h_v   = ($urandom % 3) != 0;
                h_ld  = $urandom % 2;
                h_we  = ($urandom % 4) != 0;
                h_rd  = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom);
                h_res = $urandom;
                h_sz  = 2'($urandom);
                h_sg  = $urandom % 2;
                h_off = 2'($urandom);
            end
            h_rv   = ($urandom % 4) == 0;
            h_rdat = $urandom;
            step(h_v, h_ld, h_we, h_rd, h_res, h_sz, h_sg, h_off, h_rv, h_rdat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 256, meaning the maximum number of cycles to wait for a load response (legal range 1..65535).
REQ-002 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port ex_valid, input, 1, execute result/load request present.
REQ-005 The block SHALL have port ex_ready, output, 1, block accepts ex_* this cycle.
REQ-006 The block SHALL have port ex_load, input, 1, 1 = load awaiting memory data, 0 = ALU result.
REQ-007 The block SHALL have port ex_wren, input, 1, instruction writes rd.
REQ-008 The block SHALL have port ex_rd, input, 5, destination register index.
REQ-009 The block SHALL have port ex_result, input, 32, ALU result (ignored for loads).
REQ-010 The block SHALL have port ex_lsize, input, 2, load size: 0 byte, 1 half, 2/3 word.
REQ-011 The block SHALL have port ex_lsign, input, 1, 1 = sign-extend, 0 = zero-extend.
REQ-012 The block SHALL have port ex_laddr, input, 2, load byte offset (address bits 1:0).
REQ-013 The block SHALL have port mem_rvalid, input, 1, load response valid (single-cycle pulse).
REQ-014 The block SHALL have port mem_rdata, input, 32, load response word.
REQ-015 The block SHALL have port wb_wren, output, 1, register-file write enable.
REQ-016 The block SHALL have port wb_waddr, output, 5, register-file write index.
REQ-017 The block SHALL have port wb_wdata, output, 32, register-file write data.
REQ-018 The block SHALL have port pend_valid, output, 1, a load to pend_rd is outstanding (for decode hazard stall).
REQ-019 The block SHALL have port pend_rd, output, 5, destination of the outstanding load.
REQ-020 The block SHALL have port err_timeout, output, 1, one-cycle pulse: load response not received within TIMEOUT cycles.
REQ-021 The block SHALL have port err_spurious, output, 1, one-cycle pulse: mem_rvalid with no load outstanding.

Function
REQ-022 The FSM SHALL have states IDLE and WAIT_LOAD; ex_ready = 1 only in IDLE.
REQ-023 IDLE, ex_valid=1, ex_load=0: next cycle wb_wren = ex_wren AND (ex_rd != 0), wb_waddr = ex_rd, wb_wdata = ex_result; stay IDLE (latency 1, back-to-back accept every cycle).
REQ-024 IDLE, ex_valid=1, ex_load=1: capture rd, wren, lsize, lsign, laddr; go WAIT_LOAD; clear timeout counter; no write next cycle.
REQ-025 wb_wren SHALL be a registered single-cycle pulse, deasserting the cycle after any write unless a new write is produced.
REQ-026 WAIT_LOAD, mem_rvalid=1: next cycle write aligned data (REQ-027) to captured rd if captured wren AND rd != 0; go IDLE.
REQ-027 Alignment: byte = mem_rdata[8*laddr +: 8]; half = mem_rdata[16*laddr[1] +: 16] (laddr[0] ignored); word = mem_rdata unchanged; byte/half extended per lsign to 32 bits.
REQ-028 WAIT_LOAD without mem_rvalid: counter increments; when the counter reaches TIMEOUT-1 without response, pulse err_timeout the next cycle, go IDLE, perform no write.
REQ-029 mem_rvalid on the same cycle the counter reaches TIMEOUT-1 SHALL be treated as a valid response (write, no err_timeout).
REQ-030 mem_rvalid in IDLE (including the cycle a load is accepted) SHALL be ignored for writing and pulse err_spurious the next cycle.
REQ-031 pend_valid = (state == WAIT_LOAD) AND captured wren AND captured rd != 0; pend_rd = captured rd (0 when pend_valid=0).
REQ-032 ex_valid in WAIT_LOAD SHALL not be consumed; the producer holds ex_* until ex_ready=1.

Reset
REQ-033 While rst=1 (asynchronously): state IDLE; wb_wren 0, wb_waddr 0, wb_wdata 0, pend_valid 0, pend_rd 0, err_timeout 0, err_spurious 0, counter 0; ex_ready 1 after release.
REQ-034 rst asserted mid-load SHALL abandon the load: no write or error pulse afterwards; a late mem_rvalid after release pulses err_spurious.

Verification
REQ-035 ALU x5 <= 0xDEADBEEF accepted at cycle N -> wb_wren=1, wb_waddr=5, wb_wdata=0xDEADBEEF at N+1; rd=0 -> wb_wren=0.
REQ-036 Load byte signed, laddr=3, rdata=0x80112233, rd=7 -> pend_valid=1/pend_rd=7 while waiting; write x7 = 0xFFFFFF80 the cycle after rvalid.
REQ-037 Load half unsigned, laddr=2, rdata=0xBEEF1234 -> 0x0000BEEF; word laddr=1 -> 0xBEEF1234 unchanged.
REQ-038 TIMEOUT=4, load with no response -> err_timeout pulses exactly once, no write, ex_ready=1 afterwards; rvalid on final counted cycle -> write, no error.
REQ-039 mem_rvalid in IDLE -> err_spurious one cycle, no write; rst pulsed during WAIT_LOAD -> all outputs 0 immediately, later rvalid -> err_spurious.
REQ-040 ex_valid held during WAIT_LOAD -> ex_ready=0 until response write cycle; ALU op then accepted, written one cycle after load write.
